moving_average_ctrl: RTL and testbench

Sequencer for the shaper moving-average datapath. It accepts window-size reconfiguration requests over a valid/ready handshake and validates them. On each accepted change it clears the averager, waits until the delay line and accumulator hold a full window of fresh samples, then enables the output register and flags valid averages. It sits between the slow-control register bank and the moving-average datapath, and owns that datapath's local reset, window_set and enable inputs.

---
 rtl/package_settings.sv | 20 ++
 rtl/moving_average_ctrl_timer.sv | 24 ++
 rtl/moving_average_ctrl.sv | 115 +++++++++++
 tb/tb_moving_average_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// Shared constants, state encoding and window legality check for the shaper
// moving-average datapath and its sequencer.
package package_settings;

   localparam int SIZE_MOVING_AVERAGE_WINDOW     = 8;
   localparam int SIZE_MOVING_AVERAGE_MAX_WINDOW = 64;
   localparam int MOVING_AVERAGE_CLEAR_CYCLES    = 4;
   localparam int MOVING_AVERAGE_PIPE_LATENCY    = 4;

   typedef enum logic [1:0] {CLEAR, FILL, RUN} ma_ctrl_state_t;

   // Legal windows are the non-zero powers of two up to the maximum window.
   function automatic logic is_legal_window(input logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] w);
      logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] wm1;
      wm1 = w - SIZE_MOVING_AVERAGE_WINDOW'(1);
      return (w != '0) && ((w & wm1) == '0) &&
             (32'(w) <= SIZE_MOVING_AVERAGE_MAX_WINDOW);
   endfunction

endpackage

// File: rtl/moving_average_ctrl_timer.sv
// Phase timer shared by CLEAR and FILL: counts cycles spent in the current
// phase and flags the last one, given the phase length in len_i.
module moving_average_ctrl_timer #(
   parameter int CW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic [CW-1:0] len_i,
   output logic          done_o
);

   logic [CW-1:0] cnt_q;

   // Restart from zero at every phase boundary, otherwise count up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else            cnt_q <= cnt_q + CW'(1);
   end

   assign done_o = (cnt_q == len_i - CW'(1));

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequencer for the moving-average datapath: accepts window changes, clears
// the averager, waits for a full window of fresh samples, then enables the
// output register. Reset release passes through a two-flop synchronizer, so
// the sequence starts two clk edges after the reset pin rises.
module moving_average_ctrl
   import package_settings::*;
#(
   parameter int DEFAULT_WINDOW = 1,
   parameter int CLEAR_CYCLES   = MOVING_AVERAGE_CLEAR_CYCLES,
   parameter int PIPE_LATENCY   = MOVING_AVERAGE_PIPE_LATENCY
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  cfg_valid,
   input  logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] cfg_window,
   output logic                                  cfg_ready,
   output logic                                  cfg_error,
   input  logic                                  run,
   output logic                                  ma_reset_n,
   output logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] ma_window_set,
   output logic                                  ma_enable,
   output logic                                  avg_valid,
   output logic                                  busy
);

   localparam int W  = SIZE_MOVING_AVERAGE_WINDOW;
   localparam int CW = $clog2(SIZE_MOVING_AVERAGE_MAX_WINDOW + PIPE_LATENCY + CLEAR_CYCLES + 1);

   logic [1:0]     rst_sync_q;
   logic           rst_n;
   ma_ctrl_state_t state_q;
   logic [W-1:0]   ma_window_set_q;
   logic           ma_reset_n_q, ma_enable_q, avg_valid_q;
   logic           cfg_ready_q, cfg_error_q, busy_q;

   logic           xfer, restart, tmr_clr, tmr_done;
   logic [CW-1:0]  tmr_len;

   // Assert asynchronously, release on clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign xfer    = cfg_valid & cfg_ready_q;
   assign restart = xfer & is_legal_window(cfg_window);
   // Timer is held at zero in RUN so a restart always begins CLEAR from 0.
   assign tmr_clr = restart | tmr_done | (state_q == RUN);
   assign tmr_len = (state_q == CLEAR) ? CW'(CLEAR_CYCLES)
                                       : CW'(ma_window_set_q) + CW'(PIPE_LATENCY);

   moving_average_ctrl_timer #(.CW(CW)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (tmr_clr),
      .len_i  (tmr_len),
      .done_o (tmr_done)
   );

   // Sequencer FSM; every output is a register updated with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= CLEAR;
         ma_reset_n_q    <= 1'b0;
         ma_window_set_q <= W'(DEFAULT_WINDOW);
         ma_enable_q     <= 1'b0;
         avg_valid_q     <= 1'b0;
         cfg_ready_q     <= 1'b0;
         cfg_error_q     <= 1'b0;
         busy_q          <= 1'b1;
      end else begin
         cfg_error_q <= 1'b0;
         if (restart) begin
            // Legal request (FILL or RUN): load window and start a fresh clear.
            state_q         <= CLEAR;
            ma_window_set_q <= cfg_window;
            ma_reset_n_q    <= 1'b0;
            ma_enable_q     <= 1'b0;
            avg_valid_q     <= 1'b0;
            cfg_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
         end else begin
            // Any transfer reaching here carried an illegal window.
            if (xfer) cfg_error_q <= 1'b1;
            case (state_q)
               CLEAR: if (tmr_done) begin
                  state_q      <= FILL;
                  ma_reset_n_q <= 1'b1;
                  cfg_ready_q  <= 1'b1;
               end
               FILL: if (tmr_done) begin
                  state_q     <= RUN;
                  busy_q      <= 1'b0;
                  ma_enable_q <= run;
               end
               RUN: begin
                  ma_enable_q <= run;
                  avg_valid_q <= ma_enable_q;
               end
               default: state_q <= CLEAR;
            endcase
         end
      end
   end

   assign cfg_ready     = cfg_ready_q;
   assign cfg_error     = cfg_error_q;
   assign ma_reset_n    = ma_reset_n_q;
   assign ma_window_set = ma_window_set_q;
   assign ma_enable     = ma_enable_q;
   assign avg_valid     = avg_valid_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Directed bench for the moving-average sequencer.
module tb_moving_average_ctrl;
   import package_settings::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_valid;
   logic [7:0] cfg_window;
   logic       cfg_ready, cfg_error, run;
   logic       ma_reset_n, ma_enable, avg_valid, busy;
   logic [7:0] ma_window_set;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   moving_average_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_valid     (cfg_valid),
      .cfg_window    (cfg_window),
      .cfg_ready     (cfg_ready),
      .cfg_error     (cfg_error),
      .run           (run),
      .ma_reset_n    (ma_reset_n),
      .ma_window_set (ma_window_set),
      .ma_enable     (ma_enable),
      .avg_valid     (avg_valid),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check_rst_vals(input string pfx);
      chk({pfx, " ma_reset_n"}, ma_reset_n, 0);
      chk({pfx, " window"},     ma_window_set, 1);
      chk({pfx, " ma_enable"},  ma_enable, 0);
      chk({pfx, " avg_valid"},  avg_valid, 0);
      chk({pfx, " cfg_ready"},  cfg_ready, 0);
      chk({pfx, " cfg_error"},  cfg_error, 0);
      chk({pfx, " busy"},       busy, 1);
   endtask

   // Release reset; after the two-edge synchronizer the block sits in
   // CLEAR at cycle 0. Window 1: CLEAR 0..3, FILL 4..8, enable at 9, valid at 10.
   task automatic powerup(input string pfx);
      cyc();
      reset = 1'b1;
      repeat (2) cyc();
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("%s k%0d ma_reset_n", pfx, k), ma_reset_n, (k >= 4));
         chk($sformatf("%s k%0d cfg_ready", pfx, k),  cfg_ready,  (k >= 4));
         chk($sformatf("%s k%0d ma_enable", pfx, k),  ma_enable,  (k >= 9));
         chk($sformatf("%s k%0d avg_valid", pfx, k),  avg_valid,  (k >= 10));
         chk($sformatf("%s k%0d busy", pfx, k),       busy,       (k < 9));
         cyc();
      end
      chk({pfx, " window"}, ma_window_set, 1);
   endtask

   task automatic send(input logic [7:0] w);
      cfg_valid  = 1'b1;
      cfg_window = w;
      cyc();
      cfg_valid  = 1'b0;
   endtask

   logic [7:0] bad_w [3];

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; cfg_window = '0; run = 1'b1;
      bad_w[0] = 8'd12; bad_w[1] = 8'd0; bad_w[2] = 8'd128;

      cyc();
      check_rst_vals("rst");
      powerup("pwr");

      // Legal change to 16 in RUN: CLEAR k1..4, FILL k5..24, enable k25, valid k26.
      send(8'd16);
      chk("w16 window", ma_window_set, 16);
      for (int k = 1; k <= 26; k++) begin
         chk($sformatf("w16 k%0d avg_valid", k),  avg_valid,  (k >= 26));
         chk($sformatf("w16 k%0d ma_enable", k),  ma_enable,  (k >= 25));
         chk($sformatf("w16 k%0d ma_reset_n", k), ma_reset_n, (k >= 5));
         chk($sformatf("w16 k%0d busy", k),       busy,       (k < 25));
         cyc();
      end

      // Illegal requests in RUN: one-cycle error pulse, nothing else moves.
      for (int i = 0; i < 3; i++) begin
         send(bad_w[i]);
         chk($sformatf("bad%0d cfg_error", bad_w[i]), cfg_error, 1);
         chk($sformatf("bad%0d window", bad_w[i]),    ma_window_set, 16);
         chk($sformatf("bad%0d avg_valid", bad_w[i]), avg_valid, 1);
         chk($sformatf("bad%0d busy", bad_w[i]),      busy, 0);
         cyc();
         chk($sformatf("bad%0d err_clr", bad_w[i]),   cfg_error, 0);
         chk($sformatf("bad%0d avg_valid2", bad_w[i]), avg_valid, 1);
      end

      // Window 64, then 8 issued on the 10th FILL cycle (k=14).
      send(8'd64);
      for (int k = 1; k < 14; k++) begin
         chk($sformatf("w64 k%0d avg_valid", k), avg_valid, 0);
         cyc();
      end
      chk("w64 in_fill busy", busy, 1);
      chk("w64 in_fill ready", cfg_ready, 1);
      chk("w64 in_fill ma_reset_n", ma_reset_n, 1);
      send(8'd8);
      chk("w8 window", ma_window_set, 8);
      chk("w8 restart clear", ma_reset_n, 0);
      for (int j = 1; j <= 19; j++) begin
         chk($sformatf("w8 j%0d avg_valid", j), avg_valid, (j >= 18));
         cyc();
      end

      // Drop run for 7 cycles: gating only, no refill.
      run = 1'b0;
      cyc();
      chk("run0 ma_enable", ma_enable, 0);
      chk("run0 avg_valid_lag", avg_valid, 1);
      cyc();
      chk("run0 avg_valid", avg_valid, 0);
      repeat (5) cyc();
      chk("run0 busy", busy, 0);
      chk("run0 ma_reset_n", ma_reset_n, 1);
      run = 1'b1;
      cyc();
      chk("run1 ma_enable", ma_enable, 1);
      chk("run1 avg_valid_lag", avg_valid, 0);
      cyc();
      chk("run1 avg_valid", avg_valid, 1);
      chk("run1 busy", busy, 0);

      // Reset in FILL: outputs return to reset values without a clock edge.
      send(8'd4);
      repeat (6) cyc();
      chk("midfill busy", busy, 1);
      chk("midfill ma_reset_n", ma_reset_n, 1);
      #2 reset = 1'b0;
      #1 check_rst_vals("async");
      powerup("rep");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
